matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_mac_pkg.sv | 19 +
 rtl/mm_mac_unit.sv | 40 ++++
 rtl/matrix_mac_engine.sv | 163 ++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mac_pkg.sv
// rtl/matrix_mac_pkg.sv - shared FSM state and mode encodings for the matrix MAC engine
package matrix_mac_pkg;

    // FSM state enumeration, kept as plain constants for legacy tools
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_MAC   = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Operation modes; the reserved code runs as a plain multiply
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_MUL = 2'b00;
    localparam mode_t MODE_ACC = 2'b01;
    localparam mode_t MODE_TRN = 2'b10;
    localparam mode_t MODE_RSV = 2'b11;

endpackage

// File: rtl/mm_mac_unit.sv
// rtl/mm_mac_unit.sv - multiply, extend, accumulate and overflow-detect datapath
module mm_mac_unit #(
    parameter int DW     = 8,
    parameter int AW     = 17,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [AW-1:0] acc_in,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   prod_ext;
    logic [AW:0]     wide;

    // Full-width product, extended to the accumulator width per operand signedness
    always_comb begin
        if (SIGNED != 0) begin
            prod     = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
            prod_ext = AW'($signed(prod));
        end else begin
            prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            prod_ext = AW'(prod);
        end
    end

    // Wrapping add; overflow is carry-out for unsigned, sign flip for signed
    always_comb begin
        wide = {1'b0, acc_in} + {1'b0, prod_ext};
        sum  = wide[AW-1:0];
        if (SIGNED != 0) begin
            ovf = (acc_in[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc_in[AW-1]);
        end else begin
            ovf = wide[AW];
        end
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// rtl/matrix_mac_engine.sv - sequential NxN matrix multiply/accumulate engine
module matrix_mac_engine
    import matrix_mac_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int AW     = 2*DW+$clog2(N),
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic [N*N*AW-1:0] c_flat,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int NE = N*N;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(NE);
    localparam logic [CW-1:0] CMAX = CW'(N-1);
    localparam logic [IW-1:0] NI   = IW'(N);

    state_t        state;
    mode_t         mode_q;
    logic [CW-1:0] i_cnt;
    logic [CW-1:0] j_cnt;
    logic [CW-1:0] k_cnt;
    logic [AW-1:0] acc;

    logic [DW-1:0] a_in  [NE];
    logic [DW-1:0] b_in  [NE];
    logic [DW-1:0] a_mem [NE];
    logic [DW-1:0] b_mem [NE];
    logic [AW-1:0] c_mem [NE];

    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_acc_in;
    logic [AW-1:0] mac_sum;
    logic          mac_ovf;
    logic [IW-1:0] dst_idx;
    logic          last_elem;

    function automatic logic [IW-1:0] idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * NI + IW'(c);
    endfunction

    for (genvar e = 0; e < NE; e++) begin : g_flat
        assign a_in[e]              = a_flat[e*DW +: DW];
        assign b_in[e]              = b_flat[e*DW +: DW];
        assign c_flat[e*AW +: AW]   = c_mem[e];
    end

    assign busy      = (state != ST_IDLE);
    assign last_elem = (i_cnt == CMAX) && (j_cnt == CMAX);

    // Operand selection; k=0 restarts the accumulator from zero or the previous C element
    always_comb begin
        mac_a = a_mem[idx(i_cnt, k_cnt)];
        mac_b = b_mem[idx(k_cnt, j_cnt)];
        if (k_cnt != '0) begin
            mac_acc_in = acc;
        end else if (mode_q == MODE_ACC) begin
            mac_acc_in = c_mem[idx(i_cnt, j_cnt)];
        end else begin
            mac_acc_in = '0;
        end
        dst_idx = (mode_q == MODE_TRN) ? idx(j_cnt, i_cnt) : idx(i_cnt, j_cnt);
    end

    mm_mac_unit #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
    ) u_mac (
        .a      (mac_a),
        .b      (mac_b),
        .acc_in (mac_acc_in),
        .sum    (mac_sum),
        .ovf    (mac_ovf)
    );

    // Control FSM, counters, operand/result storage and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_MUL;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
            acc    <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            a_mem  <= '{default: '0};
            b_mem  <= '{default: '0};
            c_mem  <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        mode_q <= (mode == MODE_ACC || mode == MODE_TRN) ? mode : MODE_MUL;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        a_mem <= a_in;
                        b_mem <= b_in;
                        ovf   <= 1'b0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        k_cnt <= '0;
                        acc   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= mac_sum;
                        ovf <= ovf | mac_ovf;
                        if (k_cnt == CMAX) begin
                            k_cnt <= '0;
                            state <= ST_WRITE;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        c_mem[dst_idx] <= acc;
                        if (j_cnt == CMAX) begin
                            j_cnt <= '0;
                            i_cnt <= (i_cnt == CMAX) ? '0 : i_cnt + 1'b1;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                        state <= last_elem ? ST_DONE : ST_MAC;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb/tb_matrix_mac_engine.sv - scoreboard bench for matrix_mac_engine (N=2, DW=8, AW=17)
module tb_matrix_mac_engine;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 17;

    typedef struct {
        logic [N*N*AW-1:0] c;
        logic              ovf;
        int                cyc;
        string             name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              start_u = 1'b0;
    logic              abort_u = 1'b0;
    logic [1:0]        mode_u  = 2'b00;
    logic [N*N*DW-1:0] a_u     = '0;
    logic [N*N*DW-1:0] b_u     = '0;
    logic [N*N*AW-1:0] c_u;
    logic              busy_u;
    logic              done_u;
    logic              ovf_u;

    logic              start_s = 1'b0;
    logic              abort_s = 1'b0;
    logic [1:0]        mode_s  = 2'b00;
    logic [N*N*DW-1:0] a_s     = '0;
    logic [N*N*DW-1:0] b_s     = '0;
    logic [N*N*AW-1:0] c_s;
    logic              busy_s;
    logic              done_s;
    logic              ovf_s;

    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t q_u[$];
    exp_t q_s[$];
    exp_t eu;
    exp_t es;

    matrix_mac_engine #(.N(N), .DW(DW), .AW(AW), .SIGNED(0)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start_u),
        .abort  (abort_u),
        .mode   (mode_u),
        .a_flat (a_u),
        .b_flat (b_u),
        .c_flat (c_u),
        .busy   (busy_u),
        .done   (done_u),
        .ovf    (ovf_u)
    );

    matrix_mac_engine #(.N(N), .DW(DW), .AW(AW), .SIGNED(1)) u_sdut (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .abort  (abort_s),
        .mode   (mode_s),
        .a_flat (a_s),
        .b_flat (b_s),
        .c_flat (c_s),
        .busy   (busy_s),
        .done   (done_s),
        .ovf    (ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*N*DW-1:0] pa(input int e0, input int e1, input int e2, input int e3);
        logic [DW-1:0] v0, v1, v2, v3;
        v0 = e0[DW-1:0];
        v1 = e1[DW-1:0];
        v2 = e2[DW-1:0];
        v3 = e3[DW-1:0];
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [N*N*AW-1:0] pc(input int e0, input int e1, input int e2, input int e3);
        logic [AW-1:0] v0, v1, v2, v3;
        v0 = e0[AW-1:0];
        v1 = e1[AW-1:0];
        v2 = e2[AW-1:0];
        v3 = e3[AW-1:0];
        return {v3, v2, v1, v0};
    endfunction

    // Unsigned-instance monitor: every done pops one expectation
    always @(negedge clk) begin
        if (!rst && done_u) begin
            if (q_u.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done_u: got done=1, expected no done");
            end else begin
                eu = q_u.pop_front();
                chk({eu.name, "_c"}, c_u, eu.c);
                chk({eu.name, "_ovf"}, ovf_u, eu.ovf);
                chk({eu.name, "_cycle"}, cyc, eu.cyc);
            end
        end
    end

    // Signed-instance monitor
    always @(negedge clk) begin
        if (!rst && done_s) begin
            if (q_s.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done_s: got done=1, expected no done");
            end else begin
                es = q_s.pop_front();
                chk({es.name, "_c"}, c_s, es.c);
                chk({es.name, "_ovf"}, ovf_s, es.ovf);
                chk({es.name, "_cycle"}, cyc, es.cyc);
            end
        end
    end

    task automatic wait_done(input string nm, input bit sgn);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            if (sgn ? done_s : done_u) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL %s_timeout: got no done in 30 cycles, expected done", nm);
        end
        @(negedge clk);
        chk({nm, "_done_pulse"}, sgn ? done_s : done_u, 1'b0);
    endtask

    task automatic run_op(input logic [1:0] md, input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                          input logic [N*N*AW-1:0] ec, input logic eo, input string nm, input bit poke);
        exp_t e;
        @(negedge clk);
        e.c = ec; e.ovf = eo; e.cyc = cyc + 15; e.name = nm;
        q_u.push_back(e);
        mode_u = md; a_u = a; b_u = b; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        chk({nm, "_busy"}, busy_u, 1'b1);
        @(negedge clk);
        a_u = $urandom();
        b_u = $urandom();
        mode_u = 2'b10;
        @(negedge clk);
        @(negedge clk);
        if (poke) start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        wait_done(nm, 1'b0);
    endtask

    task automatic run_s(input logic [1:0] md, input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                         input logic [N*N*AW-1:0] ec, input string nm);
        exp_t e;
        @(negedge clk);
        e.c = ec; e.ovf = 1'b0; e.cyc = cyc + 15; e.name = nm;
        q_s.push_back(e);
        mode_s = md; a_s = a; b_s = b; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_done(nm, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_c", c_u, '0);
        chk("rst_busy", busy_u, 1'b0);
        chk("rst_done", done_u, 1'b0);
        chk("rst_ovf", ovf_u, 1'b0);
        chk("rst_c_s", c_s, '0);
        rst = 1'b0;

        run_s(2'b00, pa(-1, 2, 3, -4), pa(1, 0, 0, 1), pc(-1, 2, 3, -4), "s_identity");
        run_s(2'b01, pa(-1, 2, 3, -4), pa(1, 0, 0, 1), pc(-2, 4, 6, -8), "s_acc");

        run_op(2'b00, pa(1, 2, 3, 4), pa(5, 6, 7, 8), pc(19, 22, 43, 50), 1'b0, "mul", 1'b0);
        run_op(2'b01, pa(1, 2, 3, 4), pa(5, 6, 7, 8), pc(38, 44, 86, 100), 1'b0, "acc", 1'b0);
        run_op(2'b10, pa(1, 2, 3, 4), pa(5, 6, 7, 8), pc(19, 43, 22, 50), 1'b0, "trn", 1'b0);
        run_op(2'b11, pa(1, 2, 3, 4), pa(5, 6, 7, 8), pc(19, 22, 43, 50), 1'b0, "rsv", 1'b0);
        run_op(2'b00, pa(255, 255, 255, 255), pa(255, 255, 255, 255),
               pc(130050, 130050, 130050, 130050), 1'b0, "max_mul", 1'b0);
        run_op(2'b01, pa(255, 255, 255, 255), pa(255, 255, 255, 255),
               pc(129028, 129028, 129028, 129028), 1'b1, "max_acc", 1'b0);
        chk("ovf_sticky", ovf_u, 1'b1);
        run_op(2'b00, pa(2, 0, 0, 2), pa(1, 2, 3, 4), pc(2, 4, 6, 8), 1'b0, "start_in_mac", 1'b1);

        // Abort during the second element: the first element's write must survive
        @(negedge clk);
        begin
            int n;
            n = cyc;
            mode_u = 2'b00; a_u = pa(3, 0, 0, 0); b_u = pa(3, 0, 0, 0); start_u = 1'b1;
            @(negedge clk);
            start_u = 1'b0;
            while (cyc < n + 6) @(negedge clk);
            chk("abort_busy_before", busy_u, 1'b1);
            abort_u = 1'b1;
            @(negedge clk);
            abort_u = 1'b0;
            chk("abort_busy", busy_u, 1'b0);
            chk("abort_done", done_u, 1'b0);
            chk("abort_c", c_u, pc(9, 4, 6, 8));
            repeat (20) @(negedge clk);
            chk("abort_still_idle", busy_u, 1'b0);
        end

        // Reset asserted while in WRITE clears every output without waiting for a clock
        @(negedge clk);
        begin
            int n;
            n = cyc;
            mode_u = 2'b00; a_u = pa(1, 1, 1, 1); b_u = pa(1, 1, 1, 1); start_u = 1'b1;
            @(negedge clk);
            start_u = 1'b0;
            while (cyc < n + 4) @(negedge clk);
            chk("wr_busy_before_rst", busy_u, 1'b1);
            rst = 1'b1;
            #1;
            chk("wr_rst_c", c_u, '0);
            chk("wr_rst_busy", busy_u, 1'b0);
            chk("wr_rst_done", done_u, 1'b0);
            chk("wr_rst_ovf", ovf_u, 1'b0);
            chk("wr_rst_c_s", c_s, '0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end

        run_op(2'b01, pa(1, 2, 3, 4), pa(5, 6, 7, 8), pc(19, 22, 43, 50), 1'b0, "fresh_acc", 1'b0);

        repeat (3) @(negedge clk);
        chk("pending_u", q_u.size(), 0);
        chk("pending_s", q_s.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
